// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter and boot sequencer between fetch, program loader and imem.
// Optional: define IMEM_ARB_WRITE_FLUSH_EN to pulse flush_req after each loader write in RUN.
module imem_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_done,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_stall,
  output logic          f_valid,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_valid,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          flush_req,
  output logic          booting
);

  localparam logic ST_BOOT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic       state;
  logic [7:0] starve_cnt;
  logic       starve_hit;
  logic       unused_rdata;

  // Read data is steered by the consumers using the valid tags, not here.
  assign unused_rdata = ^m_rdata;

  assign starve_hit = (starve_cnt == 8'(STARVE_MAX));

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (state == ST_BOOT) begin
      l_gnt = l_req;
    end else if (starve_hit && l_req) begin
      l_gnt = 1'b1;
    end else if (f_req) begin
      f_gnt = 1'b1;
    end else begin
      l_gnt = l_req;
    end
  end

  assign f_stall = f_req & ~f_gnt;
  assign booting = (state == ST_BOOT);
  assign m_en    = f_gnt | l_gnt;
  assign m_we    = l_gnt & l_we;
  assign m_addr  = l_gnt ? l_addr : f_addr;
  assign m_wdata = l_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      starve_cnt <= 8'd0;
      f_valid    <= 1'b0;
      l_valid    <= 1'b0;
    end else begin
      f_valid <= f_gnt;
      l_valid <= l_gnt & ~l_we;
      // Leaving BOOT waits for a cycle with no loader access in flight.
      if (state == ST_BOOT) begin
        starve_cnt <= 8'd0;
        if (boot_done && !l_gnt) state <= ST_RUN;
      end else if (l_gnt || !l_req) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != 8'hFF) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

`ifdef IMEM_ARB_WRITE_FLUSH_EN
  logic flush_q;

  always_ff @(posedge clk) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= (state == ST_RUN) & l_gnt & l_we;
  end

  assign flush_req = flush_q;
`else
  assign flush_req = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed boot/run scenarios then randomized traffic
// against a behavioural model of grants, boot progress and memory contents.
module tb_imem_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int AW         = 8;

  logic          clk = 1'b0;
  logic          rst, boot_done, f_req, l_req, l_we;
  logic [AW-1:0] f_addr, l_addr;
  logic [31:0]   l_wdata;
  logic          f_gnt, f_stall, f_valid, l_gnt, l_valid;
  logic          m_en, m_we, flush_req, booting;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [2**AW];
  logic [31:0] ref_mem [2**AW];

  // Reference model state
  bit          mdl_booting;
  int          mdl_denied;
  bit          exp_fv, exp_lv, exp_flush;
  logic [31:0] exp_data;
  bit          eg_f, eg_l;

  imem_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_stall(f_stall), .f_valid(f_valid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_valid(l_valid),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .flush_req(flush_req), .booting(booting)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("f_valid", {31'd0, f_valid}, {31'd0, exp_fv});
    check("l_valid", {31'd0, l_valid}, {31'd0, exp_lv});
    check("flush_req", {31'd0, flush_req}, {31'd0, exp_flush});
    if (exp_fv || exp_lv) check("rdata", m_rdata, exp_data);
  endtask

  task automatic applyStimulus(input bit r, input bit bd, input bit fr, input logic [AW-1:0] fa,
                               input bit lr, input bit lw, input logic [AW-1:0] la,
                               input logic [31:0] wd);
    bit ng_f, ng_l;
    @(negedge clk);
    rst = r; boot_done = bd; f_req = fr; f_addr = fa;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = wd;
    #1;
    // Boot gives the loader the memory; in run the loader wins only once it has waited its limit.
    ng_f = 0; ng_l = 0;
    if (mdl_booting) ng_l = lr;
    else if (lr && mdl_denied >= STARVE_MAX) ng_l = 1;
    else if (fr) ng_f = 1;
    else ng_l = lr;
    check("f_gnt", {31'd0, f_gnt}, {31'd0, ng_f});
    check("l_gnt", {31'd0, l_gnt}, {31'd0, ng_l});
    check("f_stall", {31'd0, f_stall}, {31'd0, fr && !ng_f});
    check("booting", {31'd0, booting}, {31'd0, mdl_booting});
    check("m_en", {31'd0, m_en}, {31'd0, ng_f || ng_l});
    check("m_we", {31'd0, m_we}, {31'd0, ng_l && lw});
    if (ng_f) check("m_addr_f", {24'd0, m_addr}, {24'd0, fa});
    if (ng_l) check("m_addr_l", {24'd0, m_addr}, {24'd0, la});
    if (ng_l && lw) check("m_wdata", m_wdata, wd);
    @(posedge clk);
    if (ng_f) exp_data = ref_mem[fa];
    if (ng_l && !lw) exp_data = ref_mem[la];
    if (ng_l && lw) ref_mem[la] = wd;
    if (r) begin
      exp_fv = 0; exp_lv = 0; exp_flush = 0;
      mdl_booting = 1; mdl_denied = 0;
    end else begin
      exp_fv = ng_f;
      exp_lv = ng_l && !lw;
`ifdef IMEM_ARB_WRITE_FLUSH_EN
      exp_flush = !mdl_booting && ng_l && lw;
`else
      exp_flush = 0;
`endif
      if (mdl_booting) begin
        mdl_denied = 0;
        if (bd && !ng_l) mdl_booting = 0;
      end else if (lr && !ng_l) begin
        mdl_denied = mdl_denied + 1;
      end else begin
        mdl_denied = 0;
      end
    end
    eg_f = ng_f; eg_l = ng_l;
    #1;
    checkOutput();
  endtask

  initial begin
    bit          fr, lr, lw, bd, r;
    logic [AW-1:0] fa, la;
    logic [31:0]   wd;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst = 1; boot_done = 0; f_req = 0; f_addr = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    repeat (2) @(posedge clk);
    mdl_booting = 1; mdl_denied = 0;
    exp_fv = 0; exp_lv = 0; exp_flush = 0; exp_data = '0;
    eg_f = 0; eg_l = 0;

    applyStimulus(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0);
    // Boot image load with fetch already knocking
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 8'h00, 1, 1, 8'(i), 32'hA5A50000 + 32'(i));
    applyStimulus(0, 1, 1, 8'h00, 1, 1, 8'h03, 32'hA5A50003);
    applyStimulus(0, 1, 1, 8'h00, 0, 0, 8'h00, 32'h0);
    applyStimulus(0, 1, 1, 8'h02, 0, 0, 8'h00, 32'h0);
    applyStimulus(0, 1, 0, 8'h00, 0, 0, 8'h00, 32'h0);

    // Both sides saturating the port
    for (int i = 0; i < 27; i++)
      applyStimulus(0, 1, 1, 8'(i % 4), 1, 0, 8'(3 - i % 4), 32'h0);
    applyStimulus(0, 1, 0, 8'h00, 1, 0, 8'h10, 32'h0);
    applyStimulus(0, 1, 0, 8'h00, 1, 1, 8'h04, 32'hDEADBEEF);
    applyStimulus(0, 1, 1, 8'h04, 0, 0, 8'h00, 32'h0);
    applyStimulus(0, 1, 0, 8'h00, 0, 0, 8'h00, 32'h0);

    // Reset with a fetch read outstanding
    applyStimulus(0, 1, 1, 8'h01, 0, 0, 8'h00, 32'h0);
    applyStimulus(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0);
    applyStimulus(0, 0, 1, 8'h02, 0, 0, 8'h00, 32'h0);

    fr = 0; lr = 0; lw = 0; bd = 0; fa = '0; la = '0; wd = '0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!bd) bd = ($urandom_range(0, 15) == 0);
      if (!fr || eg_f) begin
        fr = ($urandom_range(0, 9) < 8);
        fa = AW'($urandom_range(0, 31));
      end else if ($urandom_range(0, 19) == 0) begin
        fr = 0;
      end
      if (!lr || eg_l) begin
        lr = ($urandom_range(0, 9) < 5);
        lw = ($urandom_range(0, 1) == 1);
        la = AW'($urandom_range(0, 31));
        wd = $urandom;
      end else if ($urandom_range(0, 29) == 0) begin
        lr = 0;
      end
      applyStimulus(r, bd, fr, fa, lr, lw, la, wd);
      if (r) bd = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
